// File: rtl/or8_sweep_gen.sv
// Clocked operand sequencer for the 8-bit OR stage: sweeps x/y, waits SETTLE cycles,
// samples the stage result and records the mismatch count and first failing vector.
module or8_sweep_gen #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic        abort,
    input  logic [7:0]  dut_out,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        busy,
    output logic        done,
    output logic [16:0] err_cnt,
    output logic        first_err_valid,
    output logic [7:0]  first_err_x,
    output logic [7:0]  first_err_y,
    output logic [7:0]  first_err_out
);

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   idx;
    logic          mode_q;
    logic [CW-1:0] cnt;
    logic          last_idx;
    logic          mismatch;

    // Mode 0 drives the diagonal (x = y); mode 1 walks y fastest under x.
    function automatic logic [15:0] vec_of(input logic md, input logic [15:0] i);
        return md ? i : {i[7:0], i[7:0]};
    endfunction

    assign last_idx = mode_q ? (idx == 16'hFFFF) : (idx[7:0] == 8'hFF);
    assign mismatch = (dut_out != (x | y));
    assign busy     = (state == S_SETTLE) || (state == S_CHECK);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (cnt == CNT_LAST)  state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (abort)         state_nxt = S_IDLE;
                else if (last_idx) state_nxt = S_DONE;
                else               state_nxt = S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            mode_q          <= 1'b0;
            cnt             <= '0;
            x               <= '0;
            y               <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_x     <= '0;
            first_err_y     <= '0;
            first_err_out   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx             <= '0;
                        cnt             <= '0;
                        mode_q          <= mode;
                        x               <= '0;
                        y               <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_x     <= '0;
                        first_err_y     <= '0;
                        first_err_out   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        x <= '0;
                        y <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    // Abort wins over the compare: results of this vector are dropped.
                    if (abort) begin
                        x <= '0;
                        y <= '0;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + 17'd1;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_x     <= x;
                                first_err_y     <= y;
                                first_err_out   <= dut_out;
                            end
                        end
                        if (!last_idx) begin
                            idx      <= idx + 16'd1;
                            cnt      <= '0;
                            {x, y}   <= vec_of(mode_q, idx + 16'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
